// File: rtl/axi_stream_using_fifos.sv
// axi_stream_using_fifos: two-operand stream adder. Operand streams a and b
// are each buffered in a FIFO; when both heads exist and the sum FIFO has
// room, the heads are popped together and their modulo-2^width sum is pushed
// into the sum FIFO, which drives the sum stream.
// Optional macro AXI_STREAM_USING_FIFOS_ASSERT_EN compiles simulation-only
// immediate assertions (overflow, underflow, occupancy, sum_valid hold).

// Synchronous FIFO with separate read/write pointers and an occupancy count.
// The caller gates push with !full and pop with !empty.
module axi_stream_using_fifos_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Storage write, pointer advance with wrap at DEPTH-1, occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef AXI_STREAM_USING_FIFOS_ASSERT_EN
    // Simulation-only sanity checks on every non-reset edge.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full))  else $error("fifo: push while full");
            assert (!(pop && empty))  else $error("fifo: pop while empty");
            assert (count <= CW'(DEPTH)) else $error("fifo: occupancy %0d exceeds depth", count);
        end
    end
`endif
endmodule

module axi_stream_using_fifos #(
    parameter int width = 4,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [width-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [width-1:0] b_data,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [width-1:0] sum_data
);
    logic [width-1:0] fa_head, fb_head, fs_head, pair_sum;
    logic             fa_full, fa_empty, fb_full, fb_empty, fs_full, fs_empty;
    logic             a_push, b_push, xfer, s_pop;

    // Readies come straight from registered occupancy: a full FIFO refuses
    // even when it is being popped in the same cycle.
    assign a_ready   = !fa_full;
    assign b_ready   = !fb_full;
    assign a_push    = a_valid && a_ready;
    assign b_push    = b_valid && b_ready;
    assign xfer      = !fa_empty && !fb_empty && !fs_full;
    assign pair_sum  = fa_head + fb_head;  // carry intentionally dropped
    assign sum_valid = !fs_empty;
    assign sum_data  = fs_head;
    assign s_pop     = sum_valid && sum_ready;

    axi_stream_using_fifos_fifo #(.WIDTH(width), .DEPTH(depth)) fa (
        .clk(clk), .rst(rst), .push(a_push), .wdata(a_data), .pop(xfer),
        .head(fa_head), .full(fa_full), .empty(fa_empty)
    );

    axi_stream_using_fifos_fifo #(.WIDTH(width), .DEPTH(depth)) fb (
        .clk(clk), .rst(rst), .push(b_push), .wdata(b_data), .pop(xfer),
        .head(fb_head), .full(fb_full), .empty(fb_empty)
    );

    axi_stream_using_fifos_fifo #(.WIDTH(width), .DEPTH(depth)) fs (
        .clk(clk), .rst(rst), .push(xfer), .wdata(pair_sum), .pop(s_pop),
        .head(fs_head), .full(fs_full), .empty(fs_empty)
    );

`ifdef AXI_STREAM_USING_FIFOS_ASSERT_EN
    logic sum_pending;

    // An offered but unaccepted sum must still be offered on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_pending <= 1'b0;
        end else begin
            assert (!sum_pending || sum_valid) else $error("sum_valid dropped before accept");
            sum_pending <= sum_valid && !sum_ready;
        end
    end
`endif
endmodule

// File: tb/tb_axi_stream_using_fifos.sv
// Randomized self-checking bench for axi_stream_using_fifos. A queue-based
// reference model tracks the contents of the three buffers from the stream
// rules; scenario tasks compare DUT outputs against it and against constants.
module tb_axi_stream_using_fifos;
    localparam int W = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         a_valid, b_valid, sum_ready;
    logic [W-1:0] a_data, b_data;
    logic         a_ready, b_ready, sum_valid;
    logic [W-1:0] sum_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] mqa[$];
    logic [W-1:0] mqb[$];
    logic [W-1:0] mqs[$];

    axi_stream_using_fifos #(.width(W), .depth(D)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Advance one clock. Reports the handshakes the DUT shows before the edge
    // and advances the reference model by the stream rules.
    task automatic step(output bit a_hs, output bit b_hs, output bit s_hs,
                        output logic [W-1:0] s_dat);
        bit ma, mb, mx, mp;
        logic [W-1:0] x, y;
        a_hs  = !rst && a_valid && a_ready;
        b_hs  = !rst && b_valid && b_ready;
        s_hs  = !rst && sum_valid && sum_ready;
        s_dat = sum_data;
        if (rst) begin
            mqa.delete(); mqb.delete(); mqs.delete();
        end else begin
            ma = a_valid && (mqa.size() < D);
            mb = b_valid && (mqb.size() < D);
            mx = (mqa.size() > 0) && (mqb.size() > 0) && (mqs.size() < D);
            mp = (mqs.size() > 0) && sum_ready;
            if (mp) void'(mqs.pop_front());
            if (mx) begin
                x = mqa.pop_front();
                y = mqb.pop_front();
                mqs.push_back(W'(x + y));
            end
            if (ma) mqa.push_back(a_data);
            if (mb) mqb.push_back(b_data);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        bit h1, h2, h3;
        logic [W-1:0] d;
        rst = 1'b1;
        step(h1, h2, h3, d);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bit h1, h2, h3;
        logic [W-1:0] d;
        rst = 1'b1; a_valid = 0; b_valid = 0; sum_ready = 0; a_data = 0; b_data = 0;
        step(h1, h2, h3, d);
        rst = 1'b0;
        n_checks++; if (a_ready !== 1'b1) $display("FAIL reset_a_ready got %b exp 1", a_ready); else n_pass++;
        n_checks++; if (b_ready !== 1'b1) $display("FAIL reset_b_ready got %b exp 1", b_ready); else n_pass++;
        n_checks++; if (sum_valid !== 1'b0) $display("FAIL reset_sum_valid got %b exp 0", sum_valid); else n_pass++;
        n_checks++; if (sum_data !== '0) $display("FAIL reset_sum_data got %h exp 0", sum_data); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ah, bh, sh;
        logic [W-1:0] d;
        do_reset();
        a_valid = 1; b_valid = 1; sum_ready = 1; a_data = 3; b_data = 5;
        step(ah, bh, sh, d);              // edge N: 3 and 5 accepted
        n_checks++; if (sum_valid !== 1'b0) $display("FAIL b2b_not_yet got %b exp 0", sum_valid); else n_pass++;
        a_data = W'($urandom); b_data = W'($urandom);
        step(ah, bh, sh, d);              // edge N+1: sum pushed
        n_checks++; if (sum_valid !== 1'b1 || sum_data !== 4'd8)
            $display("FAIL b2b_first got v=%b d=%h exp v=1 d=8", sum_valid, sum_data); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            a_data = W'($urandom); b_data = W'($urandom);
            step(ah, bh, sh, d);
            n_checks++;
            if (sum_valid !== 1'b1 || mqs.size() != 1 || sum_data !== mqs[0])
                $display("FAIL b2b_stream[%0d] got v=%b d=%h exp v=1 d=%h", i, sum_valid, sum_data,
                         (mqs.size() > 0) ? mqs[0] : 4'hx);
            else n_pass++;
        end
        a_valid = 0; b_valid = 0;
    endtask

    task automatic test_wrap();
        bit ah, bh, sh;
        logic [W-1:0] d;
        do_reset();
        sum_ready = 1; a_valid = 1; b_valid = 1; a_data = 4'hC; b_data = 4'h7;
        step(ah, bh, sh, d);
        a_data = 4'hF; b_data = 4'hF;
        step(ah, bh, sh, d);
        a_valid = 0; b_valid = 0;
        n_checks++; if (sum_valid !== 1'b1 || sum_data !== 4'h3)
            $display("FAIL wrap_c_7 got v=%b d=%h exp v=1 d=3", sum_valid, sum_data); else n_pass++;
        step(ah, bh, sh, d);
        n_checks++; if (sum_valid !== 1'b1 || sum_data !== 4'hE)
            $display("FAIL wrap_f_f got v=%b d=%h exp v=1 d=e", sum_valid, sum_data); else n_pass++;
        step(ah, bh, sh, d);
        n_checks++; if (sum_valid !== 1'b0) $display("FAIL wrap_empty got %b exp 0", sum_valid); else n_pass++;
    endtask

    task automatic test_a_only_then_b();
        bit ah, bh, sh, saw_sum;
        logic [W-1:0] d, e;
        logic [W-1:0] la[$];
        logic [W-1:0] lb[$];
        int ns;
        do_reset();
        sum_ready = 1; b_valid = 0; a_valid = 1; saw_sum = 0;
        for (int i = 0; i < 20; i++) begin
            a_data = W'($urandom);
            step(ah, bh, sh, d);
            if (ah) la.push_back(a_data);
            if (sum_valid) saw_sum = 1;
        end
        n_checks++; if (la.size() != D) $display("FAIL aonly_accepts got %0d exp %0d", la.size(), D); else n_pass++;
        n_checks++; if (a_ready !== 1'b0) $display("FAIL aonly_ready got %b exp 0", a_ready); else n_pass++;
        n_checks++; if (saw_sum) $display("FAIL aonly_sum_valid got 1 exp 0"); else n_pass++;
        a_valid = 0; b_valid = 1; ns = 0;
        for (int i = 0; i < 20; i++) begin
            b_data = W'($urandom);
            step(ah, bh, sh, d);
            if (bh) lb.push_back(b_data);
            if (sh) begin
                e = W'(la[ns] + lb[ns]);
                n_checks++; if (d !== e) $display("FAIL bphase_sum[%0d] got %h exp %h", ns, d, e); else n_pass++;
                ns++;
            end
        end
        n_checks++; if (ns != D) $display("FAIL bphase_nsums got %0d exp %0d", ns, D); else n_pass++;
        n_checks++; if (lb.size() != 2 * D) $display("FAIL bphase_b_accepts got %0d exp %0d", lb.size(), 2 * D); else n_pass++;
        n_checks++; if (b_ready !== 1'b0) $display("FAIL bphase_b_ready got %b exp 0", b_ready); else n_pass++;
        b_valid = 0;
    endtask

    task automatic test_backpressure();
        bit ah, bh, sh;
        logic [W-1:0] d, e;
        logic [W-1:0] la[$];
        logic [W-1:0] lb[$];
        int ns;
        do_reset();
        sum_ready = 0; a_valid = 1; b_valid = 1;
        for (int i = 0; i < 20; i++) begin
            a_data = W'($urandom); b_data = W'($urandom);
            step(ah, bh, sh, d);
            if (ah) la.push_back(a_data);
            if (bh) lb.push_back(b_data);
        end
        n_checks++; if (la.size() != 2 * D || lb.size() != 2 * D)
            $display("FAIL bp_accepts got a=%0d b=%0d exp %0d", la.size(), lb.size(), 2 * D); else n_pass++;
        n_checks++; if (a_ready !== 1'b0 || b_ready !== 1'b0)
            $display("FAIL bp_readies got a=%b b=%b exp 0 0", a_ready, b_ready); else n_pass++;
        a_valid = 0; b_valid = 0; sum_ready = 1; ns = 0;
        for (int i = 0; i < 20; i++) begin
            step(ah, bh, sh, d);
            if (sh) begin
                e = (ns < la.size()) ? W'(la[ns] + lb[ns]) : 'x;
                n_checks++; if (d !== e) $display("FAIL bp_sum[%0d] got %h exp %h", ns, d, e); else n_pass++;
                ns++;
            end
        end
        n_checks++; if (ns != 2 * D) $display("FAIL bp_nsums got %0d exp %0d", ns, 2 * D); else n_pass++;
        n_checks++; if (sum_valid !== 1'b0) $display("FAIL bp_drained got %b exp 0", sum_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ah, bh, sh, saw;
        logic [W-1:0] d;
        do_reset();
        sum_ready = 0; a_valid = 1; b_valid = 1;
        for (int i = 0; i < 3; i++) begin
            a_data = W'($urandom); b_data = W'($urandom);
            step(ah, bh, sh, d);
        end
        b_valid = 0; a_data = W'($urandom);
        step(ah, bh, sh, d);
        // handshakes offered during the reset cycle must be ignored
        rst = 1; a_valid = 1; b_valid = 1; sum_ready = 1; a_data = 4'h9; b_data = 4'h4;
        step(ah, bh, sh, d);
        rst = 0; a_valid = 0; b_valid = 0;
        n_checks++; if (sum_valid !== 1'b0 || a_ready !== 1'b1 || b_ready !== 1'b1)
            $display("FAIL rstmid_state got sv=%b ar=%b br=%b exp 0 1 1", sum_valid, a_ready, b_ready); else n_pass++;
        saw = 0;
        for (int i = 0; i < 8; i++) begin
            step(ah, bh, sh, d);
            if (sum_valid) saw = 1;
        end
        n_checks++; if (saw) $display("FAIL rstmid_stale got sum_valid=1 exp 0"); else n_pass++;
        a_valid = 1; b_valid = 1; a_data = 4'h1; b_data = 4'h2;
        step(ah, bh, sh, d);
        a_valid = 0; b_valid = 0;
        step(ah, bh, sh, d);
        n_checks++; if (sum_valid !== 1'b1 || sum_data !== 4'h3)
            $display("FAIL rstmid_after got v=%b d=%h exp v=1 d=3", sum_valid, sum_data); else n_pass++;
        step(ah, bh, sh, d);
    endtask

    task automatic test_random();
        bit ah, bh, sh;
        logic [W-1:0] d, e;
        logic [W-1:0] la[$];
        logic [W-1:0] lb[$];
        int ns, npairs;
        do_reset();
        ns = 0;
        for (int i = 0; i < 50 + 4 * D + 10; i++) begin
            if (i < 50) begin
                a_valid = 1'($urandom_range(0, 1)); b_valid = 1'($urandom_range(0, 1));
                sum_ready = 1'($urandom_range(0, 1));
                a_data = W'($urandom); b_data = W'($urandom);
            end else begin
                a_valid = 0; b_valid = 0; sum_ready = 1;
            end
            step(ah, bh, sh, d);
            if (ah) la.push_back(a_data);
            if (bh) lb.push_back(b_data);
            if (sh) begin
                e = (ns < la.size() && ns < lb.size()) ? W'(la[ns] + lb[ns]) : 'x;
                n_checks++; if (d !== e) $display("FAIL rnd_sum[%0d] got %h exp %h", ns, d, e); else n_pass++;
                ns++;
            end
            n_checks++;
            if (a_ready !== (mqa.size() < D) || b_ready !== (mqb.size() < D) ||
                sum_valid !== (mqs.size() > 0) || (mqs.size() > 0 && sum_data !== mqs[0]))
                $display("FAIL rnd_state[%0d] got ar=%b br=%b sv=%b sd=%h exp ar=%b br=%b sv=%b",
                         i, a_ready, b_ready, sum_valid, sum_data,
                         mqa.size() < D, mqb.size() < D, mqs.size() > 0);
            else n_pass++;
        end
        npairs = (la.size() < lb.size()) ? la.size() : lb.size();
        n_checks++; if (ns != npairs) $display("FAIL rnd_count got %0d exp %0d", ns, npairs); else n_pass++;
        n_checks++; if (sum_valid !== 1'b0) $display("FAIL rnd_drained got %b exp 0", sum_valid); else n_pass++;
    endtask

    initial begin
        rst = 1; a_valid = 0; b_valid = 0; sum_ready = 0; a_data = 0; b_data = 0;
        test_reset();
        test_back_to_back();
        test_wrap();
        test_a_only_then_b();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
